// File: rtl/result_requant_my_if.sv
// rtl/result_requant_my_if.sv - single-port BRAM bus between the requant stage and the shared result memory
interface result_requant_my_if;
   logic [31:0] BRAM_ADDR;
   logic [31:0] BRAM_WRDATA;
   logic [3:0]  BRAM_WE;
   logic [31:0] BRAM_RDDATA;

   modport master (
      output BRAM_ADDR,
      output BRAM_WRDATA,
      output BRAM_WE,
      input  BRAM_RDDATA
   );

   modport slave (
      input  BRAM_ADDR,
      input  BRAM_WRDATA,
      input  BRAM_WE,
      output BRAM_RDDATA
   );
endinterface

// File: rtl/result_requant_my.sv
// rtl/result_requant_my.sv - reads int32 PE results, requantizes to int8 (round shift, ReLU, saturate), packs 4 per word
module result_requant_my #(
   parameter int H_SIZE   = 6,
   parameter int RD_LAT   = 2,
   parameter int IN_BASE  = 0,
   parameter int OUT_BASE = 256
) (
   input  logic                 S_AXI_ACLK,
   input  logic                 S_AXI_ARESETN,
   input  logic                 start,
   input  logic [4:0]           shift,
   input  logic                 relu_en,
   output logic                 busy,
   output logic                 done,
   result_requant_my_if.master  bram
);

   localparam int MW = (H_SIZE > 2) ? H_SIZE - 2 : 1;
   localparam logic [MW-1:0] M_LAST = MW'((1 << (H_SIZE - 2)) - 1);
   localparam int WW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [WW-1:0] W_LAST = WW'(RD_LAT - 1);

   typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [MW-1:0]     m_q, m_d;
   logic [1:0]        k_q, k_d;
   logic [1:0]        cap_k_q, cap_k_d;
   logic [WW-1:0]     wcnt_q, wcnt_d;
   logic [4:0]        shift_q, shift_d;
   logic              relu_q, relu_d;
   logic [RD_LAT-1:0] rd_pipe_q, rd_pipe_d;
   logic [31:0]       lanes_q, lanes_d;
   logic              issue;

   // 33-bit math keeps x + bias exact at x = 0x7FFFFFFF.
   function automatic logic [7:0] requant(input logic [31:0] x, input logic [4:0] sh, input logic relu);
      logic signed [32:0] xe;
      logic signed [32:0] b;
      logic signed [32:0] y;
      logic signed [32:0] one;
      one = 33'sd1;
      xe  = {x[31], x};
      b   = (sh == 5'd0) ? 33'sd0 : (one <<< (sh - 5'd1));
      y   = (xe + b) >>> sh;
      if (relu && y[32]) begin
         y = 33'sd0;
      end
      if (y > 33'sd127) begin
         y = 33'sd127;
      end else if (y < -33'sd128) begin
         y = -33'sd128;
      end
      return y[7:0];
   endfunction

   always_comb begin
      state_d   = state_q;
      m_d       = m_q;
      k_d       = k_q;
      cap_k_d   = cap_k_q;
      wcnt_d    = wcnt_q;
      shift_d   = shift_q;
      relu_d    = relu_q;
      lanes_d   = lanes_q;
      issue     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RD;
               shift_d = shift;
               relu_d  = relu_en;
               m_d     = '0;
               k_d     = 2'd0;
            end
         end
         S_RD: begin
            issue = 1'b1;
            k_d   = k_q + 2'd1;
            if (k_q == 2'd3) begin
               state_d = S_WAIT;
               wcnt_d  = '0;
            end
         end
         S_WAIT: begin
            if (wcnt_q == W_LAST) begin
               state_d = S_WR;
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
         end
         S_WR: begin
            if (m_q == M_LAST) begin
               state_d = S_DONE;
            end else begin
               m_d     = m_q + 1'b1;
               state_d = S_RD;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Reads return in issue order, so a wrapping lane counter tags each capture.
      rd_pipe_d = RD_LAT'({rd_pipe_q, issue});
      if (rd_pipe_q[RD_LAT-1]) begin
         lanes_d[{cap_k_q, 3'b000} +: 8] = requant(bram.BRAM_RDDATA, shift_q, relu_q);
         cap_k_d = cap_k_q + 2'd1;
      end
   end

   always_comb begin
      busy             = 1'b0;
      done             = 1'b0;
      bram.BRAM_ADDR   = 32'd0;
      bram.BRAM_WRDATA = 32'd0;
      bram.BRAM_WE     = 4'h0;
      case (state_q)
         S_RD: begin
            busy           = 1'b1;
            bram.BRAM_ADDR = 32'(IN_BASE) + (32'({m_q, k_q}) << 2);
         end
         S_WAIT: begin
            busy           = 1'b1;
            bram.BRAM_ADDR = 32'(IN_BASE) + (32'({m_q, 2'b11}) << 2);
         end
         S_WR: begin
            busy             = 1'b1;
            bram.BRAM_ADDR   = 32'(OUT_BASE) + (32'(m_q) << 2);
            bram.BRAM_WRDATA = lanes_q;
            bram.BRAM_WE     = 4'hF;
         end
         S_DONE: begin
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         state_q   <= S_IDLE;
         m_q       <= '0;
         k_q       <= 2'd0;
         cap_k_q   <= 2'd0;
         wcnt_q    <= '0;
         shift_q   <= 5'd0;
         relu_q    <= 1'b0;
         rd_pipe_q <= '0;
         lanes_q   <= 32'd0;
      end else begin
         state_q   <= state_d;
         m_q       <= m_d;
         k_q       <= k_d;
         cap_k_q   <= cap_k_d;
         wcnt_q    <= wcnt_d;
         shift_q   <= shift_d;
         relu_q    <= relu_d;
         rd_pipe_q <= rd_pipe_d;
         lanes_q   <= lanes_d;
      end
   end

endmodule
